// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, geometry and address field helpers for the 2-way data cache
package cache_pkg;
    localparam int SETS    = 64;
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = 10;
    localparam int DATA_W  = 32;
    localparam int OFF_BIT = 2;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_e;

    typedef struct packed {
        logic                   valid;
        logic [TAG_W-1:0]       tag;
        logic [1:0][DATA_W-1:0] data;
    } line_t;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return a[OFF_BIT+1 +: IDX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[OFF_BIT+1+IDX_W +: TAG_W];
    endfunction

    function automatic logic addr_word(input logic [31:0] a);
        return a[OFF_BIT];
    endfunction
endpackage

// File: rtl/cache_store.sv
// rtl/cache_store.sv - two-way tag/data arrays with per-set LRU bit and combinational lookup
module cache_store
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    idx,
    input  logic [TAG_W-1:0]    tag,
    input  logic                word,
    output logic                hit,
    output logic [DATA_W-1:0]   rd_word,
    input  logic                fill_en,
    input  logic [2*DATA_W-1:0] fill_block,
    input  logic                upd_en,
    input  logic [DATA_W-1:0]   upd_word,
    input  logic                touch_en
);
    line_t           lines_q [2][SETS];
    line_t           lines_d [2][SETS];
    logic [SETS-1:0] lru_q, lru_d;
    logic [1:0]      way_hit;
    logic            hit_way;
    logic            lru_way;

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            way_hit[w] = lines_q[w][idx].valid && (lines_q[w][idx].tag == tag);
        end
        hit     = |way_hit;
        hit_way = way_hit[1];
        lru_way = lru_q[idx];
        rd_word = lines_q[hit_way][idx].data[word];
    end

    // LRU names the way to evict next, so a touched or filled way becomes the other one
    always_comb begin
        lines_d = lines_q;
        lru_d   = lru_q;
        if (fill_en) begin
            lines_d[lru_way][idx] = {1'b1, tag, fill_block};
            lru_d[idx]            = ~lru_way;
        end else begin
            if (upd_en && hit) begin
                lines_d[hit_way][idx].data[word] = upd_word;
            end
            if (touch_en && hit) begin
                lru_d[idx] = ~hit_way;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lines_q <= '{default: '0};
            lru_q   <= '0;
        end else begin
            lines_q <= lines_d;
            lru_q   <= lru_d;
        end
    end
endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - write-through, no-write-allocate cache FSM and SRAM handshake; CACHE_STATS_EN adds hit/miss counters
module cache_controller
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_read,
    output logic        sram_write,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
`ifdef CACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);
    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        sram_read_q, sram_read_d;
    logic        sram_write_q, sram_write_d;
    logic [31:0] look_addr;
    logic        hit, fill_en, upd_en, touch_en;
    logic [31:0] hit_word;

    // Requests are only sampled in IDLE; afterwards the latched address drives the lookup
    assign look_addr = (state_q == IDLE) ? addr : addr_q;

    cache_store u_store (
        .clk        (clk),
        .rst        (rst),
        .idx        (addr_idx(look_addr)),
        .tag        (addr_tag(look_addr)),
        .word       (addr_word(look_addr)),
        .hit        (hit),
        .rd_word    (hit_word),
        .fill_en    (fill_en),
        .fill_block (sram_rdata),
        .upd_en     (upd_en),
        .upd_word   (wdata_q),
        .touch_en   (touch_en)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sram_read_d  = sram_read_q;
        sram_write_d = sram_write_q;
        ready        = 1'b1;
        rdata        = '0;
        fill_en      = 1'b0;
        upd_en       = 1'b0;
        touch_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_write) begin
                    ready        = 1'b0;
                    addr_d       = addr;
                    wdata_d      = wdata;
                    sram_write_d = 1'b1;
                    state_d      = WR_THRU;
                end else if (mem_read) begin
                    if (hit) begin
                        rdata    = hit_word;
                        touch_en = 1'b1;
                    end else begin
                        ready       = 1'b0;
                        addr_d      = addr;
                        sram_read_d = 1'b1;
                        state_d     = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                ready = 1'b0;
                if (sram_ready) begin
                    fill_en     = 1'b1;
                    rdata       = addr_word(addr_q) ? sram_rdata[63:32] : sram_rdata[31:0];
                    ready       = 1'b1;
                    sram_read_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            WR_THRU: begin
                ready = 1'b0;
                if (sram_ready) begin
                    upd_en       = 1'b1;
                    touch_en     = 1'b1;
                    ready        = 1'b1;
                    sram_write_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            sram_read_q  <= 1'b0;
            sram_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sram_read_q  <= sram_read_d;
            sram_write_q <= sram_write_d;
        end
    end

    assign sram_read  = sram_read_q;
    assign sram_write = sram_write_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == IDLE && mem_read && !mem_write && hit && hit_count_q != '1) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (state_q == RD_MISS && sram_ready && miss_count_q != '1) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - scoreboard bench for cache_controller with recency-list reference model
module tb_cache_controller;
    logic        clk;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        ready, sram_read, sram_write;
    logic [31:0] sram_addr, sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cache_controller dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_read  (sram_read),
        .sram_write (sram_write),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
`ifdef CACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] rdata;
        int          low;
        int          rp;
        int          wp;
        bit          chk_sram;
        logic [31:0] saddr;
        logic [31:0] swdata;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem  [int unsigned];
    logic [31:0] sram_mem [int unsigned];
    int unsigned rec [64][$];
    int          cur_lat = 1;
    bit          mon_en = 0;
    int          m_hits = 0;
    int          m_miss = 0;

    function automatic logic [31:0] init_word(input int unsigned k);
        return (k * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned k);
        if (ref_mem.exists(k)) return ref_mem[k];
        return init_word(k);
    endfunction

    function automatic logic [31:0] sram_rd(input int unsigned k);
        if (sram_mem.exists(k)) return sram_mem[k];
        return init_word(k);
    endfunction

    function automatic int find_tag(input int s, input int unsigned t);
        for (int i = 0; i < rec[s].size(); i++) begin
            if (rec[s][i] == t) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM: answers on the lat-th cycle that a request is visible
    int scnt = 0;
    always @(posedge clk) begin
        #2;
        if (rst || !(sram_read || sram_write)) begin
            scnt       = 0;
            sram_ready = 1'b0;
            sram_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        end else begin
            scnt++;
            if (scnt == cur_lat) begin
                sram_ready = 1'b1;
                if (sram_read)
                    sram_rdata = {sram_rd({sram_addr[31:3], 1'b1}), sram_rd({sram_addr[31:3], 1'b0})};
                if (sram_write)
                    sram_mem[sram_addr >> 2] = sram_wdata;
            end else begin
                sram_ready = 1'b0;
                sram_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            end
        end
    end

    int m_low = 0, m_rp = 0, m_wp = 0, m_cyc = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && !rst) begin
            if (mem_read || mem_write) begin
                if (sram_read) m_rp++;
                if (sram_write) m_wp++;
                m_cyc++;
                if (!ready) begin
                    m_low++;
                    if (m_cyc > 60) begin
                        checks++;
                        errors++;
                        $display("FAIL ready_timeout: ready stayed 0 for %0d cycles, required completion", m_cyc);
                        if (sb.size() > 0) e = sb.pop_front();
                        m_low = 0; m_rp = 0; m_wp = 0; m_cyc = 0;
                    end
                end else begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_response: got ready with empty scoreboard, required none");
                    end else begin
                        e = sb.pop_front();
                        check("ready_low_cycles", m_low, e.low);
                        check("sram_read_cycles", m_rp, e.rp);
                        check("sram_write_cycles", m_wp, e.wp);
                        if (!e.is_wr) check("rdata", rdata, e.rdata);
                        if (e.chk_sram) check("sram_addr", sram_addr, e.saddr);
                        if (e.is_wr) check("sram_wdata", sram_wdata, e.swdata);
                    end
                    m_low = 0; m_rp = 0; m_wp = 0; m_cyc = 0;
                end
            end else begin
                check("idle_ready", {31'b0, ready}, 32'd1);
                check("idle_sram_req", {30'b0, sram_read, sram_write}, 32'd0);
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input int lat);
        exp_t        e;
        int          s, i;
        int unsigned t, k;
        s = int'(a[8:3]);
        t = a[18:9];
        k = a >> 2;
        e = '{is_wr: 0, rdata: 0, low: 0, rp: 0, wp: 0, chk_sram: 0, saddr: 0, swdata: 0};
        i = find_tag(s, t);
        if (wr) begin
            e.is_wr = 1; e.low = lat; e.wp = lat; e.chk_sram = 1; e.saddr = a; e.swdata = wd;
            ref_mem[k] = wd;
            if (i >= 0) begin
                rec[s].delete(i);
                rec[s].push_front(t);
            end
        end else begin
            e.rdata = ref_rd(k);
            if (i >= 0) begin
                rec[s].delete(i);
                rec[s].push_front(t);
                m_hits++;
            end else begin
                e.low = lat; e.rp = lat; e.chk_sram = 1; e.saddr = a;
                rec[s].push_front(t);
                if (rec[s].size() > 2) void'(rec[s].pop_back());
                m_miss++;
            end
        end
        sb.push_back(e);
        cur_lat   = lat;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (ready) break;
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_read = 0; mem_write = 0; addr = 0; wdata = 0;
        sram_ready = 0; sram_rdata = 0;
        #2;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_rdata", rdata, 32'd0);
        check("rst_sram_req", {30'b0, sram_read, sram_write}, 32'd0);
        check("rst_sram_addr", sram_addr, 32'd0);
        check("rst_sram_wdata", sram_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ref_mem[32'h100]  = 32'hAAAA_AAAA;  ref_mem[32'h101]  = 32'hBBBB_BBBB;
        sram_mem[32'h100] = 32'hAAAA_AAAA;  sram_mem[32'h101] = 32'hBBBB_BBBB;
        mon_en = 1;

        issue(1, 0, 32'h400, 0, 4);
        issue(1, 0, 32'h404, 0, 1);
        issue(1, 0, 32'h600, 0, 2);
        issue(1, 0, 32'h800, 0, 3);
        issue(1, 0, 32'h600, 0, 1);
        issue(1, 0, 32'h400, 0, 2);
        issue(0, 1, 32'h400, 32'h1234_5678, 2);
        issue(1, 0, 32'h400, 0, 1);
        issue(0, 1, 32'hA00, 32'hCAFE_F00D, 3);
        issue(1, 0, 32'hA00, 0, 2);
        issue(1, 1, 32'h404, 32'h0BAD_F00D, 1);
        issue(1, 0, 32'h404, 0, 1);

        mon_en    = 0;
        cur_lat   = 1000;
        addr      = 32'h3000;
        mem_read  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b1;
        mem_read = 1'b0;
        #1;
        check("rst_mid_miss_sram_read", {31'b0, sram_read}, 32'd0);
        check("rst_mid_miss_ready", {31'b0, ready}, 32'd1);
        check("rst_mid_miss_sram_addr", sram_addr, 32'd0);
`ifdef CACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 64; s++) rec[s].delete();
        m_hits = 0;
        m_miss = 0;
        @(posedge clk);
        #1;
        mon_en = 1;
        issue(1, 0, 32'h3000, 0, 2);
        issue(1, 0, 32'h3004, 0, 1);
        issue(1, 0, 32'h400, 0, 1);

        repeat (300) begin
            logic [31:0] a;
            int          op;
            bit          rd, wr;
            op = int'($urandom_range(0, 9));
            rd = (op < 6) || (op == 9);
            wr = (op >= 6);
            a  = {13'b0, 10'(10'h05 + $urandom_range(0, 3)), 6'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), 2'b00};
            issue(rd, wr, a, $urandom, int'($urandom_range(1, 4)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_miss);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate data cache controller between the MEM stage and the SRAM controller.
- Holds tag, valid and LRU state and the data arrays.
- Serves read hits in zero cycles and sequences SRAM reads on misses and SRAM writes on every store.
- Drives `ready` low while it waits on SRAM; the pipeline uses this as its freeze signal.

Parameters:
- SETS, 64, number of sets (index width = log2(SETS) = 6).
- TAG_W, 10, tag width; address bits [18:9] with defaults.
- DATA_W, 32, word width; a block is 2 words (64 bits).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- mem_read  in  1  load request from MEM stage
- mem_write  in  1  store request from MEM stage
- addr  in  32  byte address; bit[2] selects word, [8:3] index, [18:9] tag
- wdata  in  32  store data
- rdata  out  32  load data
- ready  out  1  request complete this cycle; low means freeze
- sram_read  out  1  SRAM block-read request
- sram_write  out  1  SRAM word-write request
- sram_addr  out  32  SRAM address, latched at request start
- sram_wdata  out  32  SRAM write data, latched
- sram_rdata  in  64  block returned by SRAM, {word1, word0}
- sram_ready  in  1  SRAM access complete (single-cycle pulse)

Behaviour:
- **Reset (async):**
  - All valid bits = 0, all LRU bits = 0, state = IDLE.
  - rdata = 0, ready = 1, sram_read = 0, sram_write = 0, sram_addr = 0, sram_wdata = 0.
  - Reset mid-miss or mid-write aborts the access immediately; no array update happens.
- **States:** IDLE, RD_MISS, WR_THRU.
- **IDLE, no request:** ready = 1.
- **IDLE, read hit** (valid and tag match in either way):
  - rdata = selected word combinationally, ready = 1 the same cycle.
  - LRU[set] := 1 if way0 hit, 0 if way1 hit (LRU names the way to evict next).
- **IDLE, read miss:**
  - ready = 0; latch addr; sram_read = 1 from the next edge; go to RD_MISS.
- **RD_MISS:**
  - Hold sram_read = 1 until sram_ready.
  - On sram_ready:
    - Write sram_rdata into way LRU[set]; set valid and tag; flip LRU[set].
    - rdata = requested word from sram_rdata; ready = 1 that cycle; sram_read := 0; go to IDLE.
- **IDLE, write** (hit or miss): ready = 0; latch addr and wdata; sram_write = 1; go to WR_THRU.
- **WR_THRU:**
  - On sram_ready: ready = 1 that cycle; sram_write := 0; go to IDLE.
  - On a write hit, the matching word is updated in place at that edge and LRU[set] is updated as for a read hit.
  - On a write miss, the arrays are unchanged.
- **Simultaneous mem_read and mem_write:** treated as a write.
- **Request inputs while state ≠ IDLE:** ignored; latched values are used.
- **Both ways valid with the same tag:** cannot occur; a fill targets only a missing tag.
- **sram_ready while IDLE:** ignored.
- **Latency:**
  - Read hit: 0 cycles.
  - Read miss and write: 1 + SRAM latency cycles.
  - There is always at least 1 cycle of ready = 0.

Optional Feature:
- **CACHE_STATS_EN defined:**
  - Adds outputs hit_count [31:0] and miss_count [31:0], reset to 0.
  - hit_count increments on each completed read hit; miss_count increments on each RD_MISS completion.
  - Writes are not counted. Counters saturate at all-ones.
- **Not defined:** the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- **cache_pkg:**
  - state enum {IDLE, RD_MISS, WR_THRU}.
  - Localparams IDX_W, TAG_W, OFF_BIT; address field extract functions.
  - Typedef line_t {valid, tag, data[2]}.
- **Sub-module cache_store:**
  - Two-way arrays plus LRU bits, with async clear on rst.
  - Combinational lookup returning hit, hit_way and word.
  - Write ports for fill (way, block) and word update.
- cache_controller keeps the FSM, latches and SRAM handshake.

Test Plan:
- Reset, then read 0x0000_0400 with SRAM returning {0xBBBB_BBBB, 0xAAAA_AAAA} after 3 cycles → ready low 4 cycles, rdata = 0xAAAA_AAAA, sram_read pulse train of 4 cycles; immediate re-read of 0x404 → ready = 1 same cycle, rdata = 0xBBBB_BBBB, no sram_read.
- Fill 0x400 (way0), then 0x600 (same index, way1), then read 0x800 → evicts way0; read 0x600 hits; read 0x400 misses.
- Write 0x400 = 0x1234_5678 after a fill → sram_write with sram_addr = 0x400, sram_wdata = 0x1234_5678; ready after sram_ready; next read 0x400 hits, returns 0x1234_5678.
- Write to 0x0A00, not cached → SRAM write only; subsequent read 0xA00 misses.
- Assert rst during RD_MISS → sram_read = 0 immediately; after release, read of the same address misses again.
- With CACHE_STATS_EN defined: 2 misses and 3 hits → hit_count = 3, miss_count = 2; mem_read and mem_write together → treated as write, counters unchanged.
